// File: rtl/memory_bus_arbiter.sv
// Arbitrates one single-port memory between debug, data and instruction-fetch requesters.
// One transaction at a time; acks and read data are registered per port.
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ack,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_INST = 2'd1;
  localparam logic [1:0] GNT_DATA = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;
  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [1:0]            grant_q;
  logic [1:0]            sel_d;
  logic                  busy_q;
  logic                  we_q;
  logic                  last_data_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic                  inst_ack_q;
  logic                  data_ack_q;
  logic                  dbg_ack_q;
  logic                  finish_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] inst_rdata_q;
  logic [DATA_WIDTH-1:0] data_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;

  // dbg has absolute priority; inst/data alternate when both are waiting.
  always_comb begin
    sel_d = GNT_NONE;
    if (dbg_req)                    sel_d = GNT_DBG;
    else if (inst_req && data_req)  sel_d = last_data_q ? GNT_INST : GNT_DATA;
    else if (inst_req)              sel_d = GNT_INST;
    else if (data_req)              sel_d = GNT_DATA;
  end

  // High in the last cycle before RESP, so ack and rdata load on the same edge.
  always_comb begin
    finish_d = 1'b0;
    if (state_q == S_ACCESS)    finish_d = we_q || (READ_LATENCY == 1);
    else if (state_q == S_WAIT) finish_d = (cnt_q == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grant_q      <= GNT_NONE;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_data_q  <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      inst_ack_q <= 1'b0;
      data_ack_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_d != GNT_NONE) begin
            grant_q  <= sel_d;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            state_q  <= S_ACCESS;
            case (sel_d)
              GNT_DBG: begin
                addr_q   <= dbg_addr;
                wdata_q  <= dbg_wdata;
                we_q     <= dbg_we;
                mem_we_q <= dbg_we;
              end
              GNT_DATA: begin
                addr_q      <= data_addr;
                wdata_q     <= data_wdata;
                we_q        <= data_we;
                mem_we_q    <= data_we;
                last_data_q <= 1'b1;
              end
              default: begin
                addr_q      <= inst_addr;
                we_q        <= 1'b0;
                last_data_q <= 1'b0;
              end
            endcase
          end
        end
        S_ACCESS: begin
          cnt_q   <= CNT_LOAD;
          state_q <= finish_d ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (finish_d) state_q <= S_RESP;
        end
        S_RESP: begin
          grant_q <= GNT_NONE;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (finish_d) begin
        case (grant_q)
          GNT_INST: begin
            inst_ack_q   <= 1'b1;
            inst_rdata_q <= mem_rdata;
          end
          GNT_DATA: begin
            data_ack_q <= 1'b1;
            if (!we_q) data_rdata_q <= mem_rdata;
          end
          GNT_DBG: begin
            dbg_ack_q <= 1'b1;
            if (!we_q) dbg_rdata_q <= mem_rdata;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign inst_ack   = inst_ack_q;
  assign data_ack   = data_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference (winner choice, transaction length, reference memory).
module tb_memory_bus_arbiter;

  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_init;
  logic [3:1]  rq;
  logic [3:1]  rwe;
  logic [3:1]  hold;
  logic [31:0] raddr [1:3];
  logic [31:0] rwd   [1:3];

  logic [31:0] dbg_rdata, data_rdata, inst_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        dbg_ack, data_ack, inst_ack, mem_en, mem_we, busy;
  logic [1:0]  grant;

  memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(rst),
    .dbg_req(rq[3]), .dbg_we(rwe[3]), .dbg_addr(raddr[3]), .dbg_wdata(rwd[3]),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .data_req(rq[2]), .data_we(rwe[2]), .data_addr(raddr[2]), .data_wdata(rwd[2]),
    .data_rdata(data_rdata), .data_ack(data_ack),
    .inst_req(rq[1]), .inst_addr(raddr[1]), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA5A50000 | 32'(i);
  endfunction

  // Memory array seen by the arbiter: combinational read of the held address.
  logic [31:0] emem [0:63];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) emem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      emem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = emem[mem_addr[5:0]];

  // Second instance with the longest read latency, inst port only.
  logic        r4, i4_req, z4;
  logic [31:0] i4_addr, zero32;
  logic [31:0] o4_dbg_rdata, o4_data_rdata, o4_inst_rdata, o4_addr, o4_wdata, m4_rdata;
  logic        o4_dbg_ack, o4_data_ack, o4_inst_ack, o4_en, o4_we, o4_busy;
  logic [1:0]  o4_grant;

  memory_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(4)) u4 (
    .clk(clk), .reset(r4),
    .dbg_req(z4), .dbg_we(z4), .dbg_addr(zero32), .dbg_wdata(zero32),
    .dbg_rdata(o4_dbg_rdata), .dbg_ack(o4_dbg_ack),
    .data_req(z4), .data_we(z4), .data_addr(zero32), .data_wdata(zero32),
    .data_rdata(o4_data_rdata), .data_ack(o4_data_ack),
    .inst_req(i4_req), .inst_addr(i4_addr), .inst_rdata(o4_inst_rdata), .inst_ack(o4_inst_ack),
    .mem_en(o4_en), .mem_we(o4_we), .mem_addr(o4_addr), .mem_wdata(o4_wdata),
    .mem_rdata(m4_rdata), .grant(o4_grant), .busy(o4_busy)
  );
  assign m4_rdata = init_val(int'(o4_addr[5:0]));

  int checks = 0;
  int failures = 0;

  // Reference model: transaction owner, length and progress, plus a shadow memory.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rd  [1:3];
  int          m_cnt, m_len, m_owner;
  logic        m_we, m_last_data, rnd_mode;
  logic [31:0] m_addr, m_wd;
  int          ack_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_cnt = 0;
      m_last_data = 1'b1;
      for (int p = 1; p <= 3; p++) exp_rd[p] = '0;
    end else if (m_cnt == 0) begin
      if (rq != 3'b000) begin
        if (rq[3])              m_owner = 3;
        else if (rq[1] && rq[2]) m_owner = m_last_data ? 1 : 2;
        else                    m_owner = rq[1] ? 1 : 2;
        if (m_owner == 1) m_last_data = 1'b0;
        else if (m_owner == 2) m_last_data = 1'b1;
        m_we   = (m_owner == 1) ? 1'b0 : rwe[m_owner];
        m_addr = raddr[m_owner];
        m_wd   = rwd[m_owner];
        m_len  = m_we ? 2 : RL + 1;
        if (m_we) ref_mem[m_addr[5:0]] = m_wd;
        m_cnt  = 1;
      end
    end else if (m_cnt == m_len) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == m_len && !m_we) exp_rd[m_owner] = ref_mem[m_addr[5:0]];
    end
  endtask

  task automatic check_outputs();
    logic resp;
    resp = (m_cnt != 0) && (m_cnt == m_len);
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("grant", 32'(grant), 32'(m_cnt != 0 ? m_owner : 0));
    chk("mem_en", 32'(mem_en), 32'(m_cnt == 1));
    chk("mem_we", 32'(mem_we), 32'(m_cnt == 1 && m_we));
    if (m_cnt == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
    chk("inst_ack", 32'(inst_ack), 32'(resp && m_owner == 1));
    chk("data_ack", 32'(data_ack), 32'(resp && m_owner == 2));
    chk("dbg_ack", 32'(dbg_ack), 32'(resp && m_owner == 3));
    chk("inst_rdata", inst_rdata, exp_rd[1]);
    chk("data_rdata", data_rdata, exp_rd[2]);
    chk("dbg_rdata", dbg_rdata, exp_rd[3]);
  endtask

  task automatic new_req(input int p);
    rq[p]    = 1'b1;
    rwe[p]   = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    raddr[p] = 32'($urandom_range(0, 63));
    rwd[p]   = $urandom;
  endtask

  task automatic tick();
    logic resp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (inst_ack) ack_log.push_back(1);
    if (data_ack) ack_log.push_back(2);
    if (dbg_ack)  ack_log.push_back(3);
    resp = (m_cnt != 0) && (m_cnt == m_len);
    for (int p = 1; p <= 3; p++) begin
      if (resp && m_owner == p && !hold[p]) rq[p] = 1'b0;
      if (rnd_mode && !rq[p] && $urandom_range(0, 3) == 0) new_req(p);
    end
  endtask

  task automatic wait_acks(input int n, input int limit);
    int k = 0;
    while (ack_log.size() < n && k < limit) begin
      tick();
      k++;
    end
    chk("ack_count", 32'(ack_log.size()), 32'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1; rq = '0; rwe = '0; hold = '0; rnd_mode = 1'b0;
    r4 = 1'b1; i4_req = 1'b0; i4_addr = '0; z4 = 1'b0; zero32 = '0;
    for (int p = 1; p <= 3; p++) begin raddr[p] = '0; rwd[p] = '0; exp_rd[p] = '0; end
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    m_cnt = 0; m_len = 3; m_owner = 0; m_we = 1'b0; m_last_data = 1'b1;
    m_addr = '0; m_wd = '0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    mem_init = 1'b0;
    rst = 1'b0;
    tick();

    // Single inst read at 0x10
    rq[1] = 1'b1; raddr[1] = 32'h10;
    tick();
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_grant_c1", 32'(grant), 32'd1);
    tick();
    chk("t1_grant_c2", 32'(grant), 32'd1);
    chk("t1_ack_c2", 32'(inst_ack), 32'd0);
    tick();
    chk("t1_inst_ack", 32'(inst_ack), 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'hDEADBEEF);
    chk("t1_grant_c3", 32'(grant), 32'd1);
    tick();
    chk("t1_idle_grant", 32'(grant), 32'd0);

    // Data write, then read it back on data and inst ports
    rq[2] = 1'b1; rwe[2] = 1'b1; raddr[2] = 32'h20; rwd[2] = 32'h12345678;
    tick();
    chk("t2_mem_en", 32'(mem_en), 32'd1);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    chk("t2_data_ack", 32'(data_ack), 32'd1);
    chk("t2_data_rdata", data_rdata, 32'h0);
    rq[2] = 1'b1; rwe[2] = 1'b0;
    ack_log.delete();
    wait_acks(1, 10);
    chk("t2_readback", data_rdata, 32'h12345678);
    rq[1] = 1'b1; raddr[1] = 32'h20;
    ack_log.delete();
    wait_acks(1, 10);
    chk("t2_inst_readback", inst_rdata, 32'h12345678);
    tick();

    // inst and data both held after reset: strict alternation starting with inst
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hold[1] = 1'b1; hold[2] = 1'b1;
    rq[1] = 1'b1; raddr[1] = 32'h1;
    rq[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 32'h2;
    ack_log.delete();
    wait_acks(4, 40);
    rq[1] = 1'b0; rq[2] = 1'b0; hold = '0;
    chk("t3_order0", 32'(ack_log[0]), 32'd1);
    chk("t3_order1", 32'(ack_log[1]), 32'd2);
    chk("t3_order2", 32'(ack_log[2]), 32'd1);
    chk("t3_order3", 32'(ack_log[3]), 32'd2);
    tick();

    // dbg arrives while inst waits, data pending; pointer untouched by dbg
    hold[1] = 1'b1; hold[2] = 1'b1;
    rq[1] = 1'b1; raddr[1] = 32'h3;
    rq[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 32'h4;
    ack_log.delete();
    tick();
    tick();
    chk("t4_grant_inst", 32'(grant), 32'd1);
    rq[3] = 1'b1; rwe[3] = 1'b1; raddr[3] = 32'h30; rwd[3] = 32'hCAFEF00D;
    wait_acks(4, 60);
    rq = '0; hold = '0;
    chk("t4_order0", 32'(ack_log[0]), 32'd1);
    chk("t4_order1", 32'(ack_log[1]), 32'd3);
    chk("t4_order2", 32'(ack_log[2]), 32'd2);
    chk("t4_order3", 32'(ack_log[3]), 32'd1);
    tick();

    // Reset during WAIT of a data read
    rq[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 32'h7;
    tick();
    tick();
    chk("t5_wait_grant", 32'(grant), 32'd2);
    rst = 1'b1; rq[2] = 1'b0;
    tick();
    chk("t5_no_ack", 32'(data_ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_data_rdata", data_rdata, 32'h0);
    rst = 1'b0;
    rq[1] = 1'b1; raddr[1] = 32'h10;
    rq[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 32'h8;
    ack_log.delete();
    tick();
    chk("t5_ptr_reset", 32'(grant), 32'd1);
    wait_acks(2, 20);
    chk("t5_order0", 32'(ack_log[0]), 32'd1);
    chk("t5_order1", 32'(ack_log[1]), 32'd2);
    chk("t5_inst_rdata", inst_rdata, 32'hDEADBEEF);
    tick();

    // Random traffic
    rnd_mode = 1'b1;
    repeat (1500) tick();
    rnd_mode = 1'b0;
    repeat (20) tick();
    rq = '0;
    repeat (3) tick();

    // READ_LATENCY=4 instance: continuous inst reads, one ack every 6 cycles
    r4 = 1'b0; i4_req = 1'b1; i4_addr = 32'h5;
    for (int j = 1; j <= 36; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rl4_mem_en", 32'(o4_en), 32'(j % 6 == 1));
      chk("rl4_ack", 32'(o4_inst_ack), 32'(j % 6 == 5));
      if (j % 6 == 1) chk("rl4_mem_addr", o4_addr, 32'h5);
      if (j % 6 == 5) chk("rl4_rdata", o4_inst_rdata, init_val(5));
    end
    i4_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
